// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: next-PC mode encodings and default parameters.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JREG   = 3'd3,
    SEL_RET    = 3'd4
  } pc_sel_e;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam int unsigned DEF_RESET_VECTOR = 0;
  localparam int unsigned DEF_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch controller (master) and the PC sequencer (slave).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             stall;
  logic [2:0]       pc_sel;
  logic             call;
  logic [WIDTH-1:0] branch_off;
  logic [25:0]      jump_idx;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus4;
  logic             addr_err;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, pc_sel, call, branch_off, jump_idx, reg_target,
    input  pc_out, pc_plus4, addr_err, ras_empty, ras_full
  );

  modport slave (
    input  stall, pc_sel, call, branch_off, jump_idx, reg_target,
    output pc_out, pc_plus4, addr_err, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module return_addr_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;

  logic [PW-1:0]    w_top_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = r_empty;
  assign full      = r_full;

  // Pop+push together replaces the top in place: pointer and count stay put.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    if (push && !pop) begin
      w_ptr_nxt = r_ptr + PW'(1);
      if (r_count != CW'(DEPTH)) w_count_nxt = r_count + CW'(1);
    end else if (pop && !push) begin
      w_ptr_nxt   = w_top_idx;
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[pop ? w_top_idx : r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, target alignment check and return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int unsigned      RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input logic           clk,
  input logic           reset_n,
  pc_sequencer_if.slave bus
);
  logic [WIDTH-1:0] r_pc;
  logic             r_addr_err;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch;
  logic [WIDTH-1:0] w_jump;
  logic [27:0]      w_jfield;
  logic [WIDTH-1:0] w_cand;
  logic             w_bad;
  logic             w_ret;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_top;
  logic             w_empty;
  logic             w_full;

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_branch   = w_pc_plus4 + (bus.branch_off << 2);
  assign w_jfield   = {bus.jump_idx, 2'b00};

  // Narrow PCs keep only the low bits of the jump field.
  if (WIDTH > 28) begin : g_jump_wide
    assign w_jump = {w_pc_plus4[WIDTH-1:28], w_jfield};
  end else begin : g_jump_narrow
    assign w_jump = w_jfield[WIDTH-1:0];
  end

  always_comb begin
    w_cand = w_pc_plus4;
    w_bad  = 1'b0;
    w_ret  = 1'b0;
    case (bus.pc_sel)
      SEL_BRANCH: w_cand = w_branch;
      SEL_JUMP:   w_cand = w_jump;
      SEL_JREG: begin
        w_cand = bus.reg_target;
        w_bad  = |bus.reg_target[1:0];
      end
      SEL_RET: begin
        w_cand = w_top;
        w_bad  = w_empty;
        w_ret  = 1'b1;
      end
      default: w_cand = w_pc_plus4;
    endcase
  end

  assign w_push = !bus.stall && !w_bad && bus.call;
  assign w_pop  = !bus.stall && !w_bad && w_ret;

  return_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (w_top),
    .empty     (w_empty),
    .full      (w_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_VECTOR;
      r_addr_err <= 1'b0;
    end else if (bus.stall) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_bad;
      if (!w_bad) r_pc <= w_cand;
    end
  end

  assign bus.pc_out    = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.addr_err  = r_addr_err;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = w_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle plus literal pins.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_stack[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic st, input logic [2:0] sel, input logic cl,
                            input logic [31:0] boff, input logic [25:0] jidx,
                            input logic [31:0] rt);
    logic [31:0] pp4, nxt;
    logic        bad;
    pp4 = m_pc + 32'd4;
    nxt = pp4;
    bad = 1'b0;
    if (st) begin
      m_err = 1'b0;
    end else begin
      case (sel)
        3'd1: nxt = pp4 + (boff << 2);
        3'd2: nxt = {pp4[31:28], jidx, 2'b00};
        3'd3: begin nxt = rt; bad = (rt[1:0] != 2'b00); end
        3'd4: if (m_stack.size() == 0) bad = 1'b1; else nxt = m_stack[$];
        default: nxt = pp4;
      endcase
      if (!bad) begin
        if (sel == 3'd4) void'(m_stack.pop_back());
        if (cl) begin
          m_stack.push_back(pp4);
          if (m_stack.size() > 4) void'(m_stack.pop_front());
        end
        m_pc = nxt;
      end
      m_err = bad;
    end
  endtask

  task automatic cyc(input logic st, input logic [2:0] sel, input logic cl,
                     input logic [31:0] boff, input logic [25:0] jidx,
                     input logic [31:0] rt);
    bus.stall      = st;
    bus.pc_sel     = sel;
    bus.call       = cl;
    bus.branch_off = boff;
    bus.jump_idx   = jidx;
    bus.reg_target = rt;
    @(posedge clk);
    model_step(st, sel, cl, boff, jidx, rt);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out",    bus.pc_out,             m_pc);
      check("pc_plus4",  bus.pc_plus4,           m_pc + 32'd4);
      check("addr_err",  32'(bus.addr_err),      32'(m_err));
      check("ras_empty", 32'(bus.ras_empty),     32'(m_stack.size() == 0));
      check("ras_full",  32'(bus.ras_full),      32'(m_stack.size() == 4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall = 1'b0; bus.pc_sel = 3'd0; bus.call = 1'b0;
    bus.branch_off = '0; bus.jump_idx = '0; bus.reg_target = '0;
    model_reset();
    #12;
    check("rst_pc",    bus.pc_out,           32'h0);
    check("rst_empty", 32'(bus.ras_empty),   32'd1);
    check("rst_full",  32'(bus.ras_full),    32'd0);
    check("rst_err",   32'(bus.addr_err),    32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("seq1", bus.pc_out, 32'h4);
    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("seq2", bus.pc_out, 32'h8);
    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("seq3", bus.pc_out, 32'hC);
    check("seq_empty", 32'(bus.ras_empty), 32'd1);
    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("seq4", bus.pc_out, 32'h10);

    cyc(0, SEL_BRANCH, 0, 32'hFFFF_FFFE, 0, 0); check("branch_neg", bus.pc_out, 32'hC);
    cyc(0, SEL_JUMP, 0, 0, 26'h40, 0);          check("jump", bus.pc_out, 32'h100);
    cyc(0, SEL_JREG, 0, 0, 0, 32'h202);
    check("jreg_mis_pc", bus.pc_out, 32'h100);
    check("jreg_mis_err", 32'(bus.addr_err), 32'd1);
    cyc(0, SEL_SEQ, 0, 0, 0, 0);
    check("err_clear", 32'(bus.addr_err), 32'd0);
    check("after_err_pc", bus.pc_out, 32'h104);

    cyc(0, SEL_JREG, 0, 0, 0, 32'h20);           check("jreg", bus.pc_out, 32'h20);
    cyc(0, SEL_JUMP, 1, 0, 26'h100, 0);          check("call_jump", bus.pc_out, 32'h400);
    cyc(0, SEL_RET, 0, 0, 0, 0);                 check("ret", bus.pc_out, 32'h24);
    check("ret_empty", 32'(bus.ras_empty), 32'd1);

    for (int unsigned k = 0; k < 5; k++) begin
      cyc(0, SEL_JREG, 1, 0, 0, 32'h1000 + 32'h100 * k);
      if (k == 3) check("full_after4", 32'(bus.ras_full), 32'd1);
    end
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret1", bus.pc_out, 32'h1304);
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret2", bus.pc_out, 32'h1204);
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret3", bus.pc_out, 32'h1104);
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret4", bus.pc_out, 32'h1004);
    cyc(0, SEL_RET, 0, 0, 0, 0);
    check("ret_empty_pc", bus.pc_out, 32'h1004);
    check("ret_empty_err", 32'(bus.addr_err), 32'd1);

    cyc(0, SEL_SEQ, 1, 0, 0, 0); check("call_seq", bus.pc_out, 32'h1008);
    cyc(1, SEL_SEQ, 1, 0, 0, 0);
    cyc(1, SEL_SEQ, 1, 0, 0, 0);
    check("stall_pc", bus.pc_out, 32'h1008);
    check("stall_empty", 32'(bus.ras_empty), 32'd0);
    cyc(0, SEL_RET, 0, 0, 0, 0);
    check("stall_no_push", bus.pc_out, 32'h1008);
    check("stall_no_push_empty", 32'(bus.ras_empty), 32'd1);

    // Asynchronous reset asserted mid-cycle while stalled.
    bus.stall = 1'b1; bus.pc_sel = SEL_SEQ; bus.call = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("async_rst_pc", bus.pc_out, 32'h0);
    check("async_rst_empty", 32'(bus.ras_empty), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.stall = 1'b0; bus.call = 1'b0;

    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("post_rst", bus.pc_out, 32'h4);
    cyc(0, SEL_JREG, 0, 0, 0, 32'hFFFF_FFFC);
    cyc(0, SEL_SEQ, 0, 0, 0, 0); check("wrap", bus.pc_out, 32'h0);
    cyc(0, SEL_JREG, 1, 0, 0, 32'h200);
    cyc(0, SEL_JREG, 1, 0, 0, 32'h300);
    cyc(0, SEL_RET, 1, 0, 0, 0); check("ret_call_pc", bus.pc_out, 32'h204);
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret_call_top", bus.pc_out, 32'h304);
    cyc(0, SEL_RET, 0, 0, 0, 0); check("ret_call_old", bus.pc_out, 32'h4);
    check("ret_call_empty", 32'(bus.ras_empty), 32'd1);
    cyc(0, 3'd6, 0, 0, 0, 0);    check("sel6_seq", bus.pc_out, 32'h8);

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits (at least 8).
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded by reset; word-aligned.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hold all state this cycle.
REQ-007 pc_sel  input  3  next-PC mode: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 RET; 5-7 behave as SEQ.
REQ-008 call  input  1  push pc_plus4 onto the return-address stack on a non-stalled update.
REQ-009 branch_off  input  WIDTH  signed word offset for BRANCH.
REQ-010 jump_idx  input  26  word index for JUMP.
REQ-011 reg_target  input  WIDTH  byte address for JREG.
REQ-012 pc_out  output  WIDTH  current PC, registered.
REQ-013 pc_plus4  output  WIDTH  pc_out + 4, combinational, modulo 2^WIDTH.
REQ-014 addr_err  output  1  registered one-cycle pulse on a rejected target.
REQ-015 ras_empty / ras_full  output  1 each  registered stack status.

Function
REQ-016 Next-PC rules: SEQ gives pc_plus4; BRANCH gives pc_plus4 + (branch_off << 2); JUMP gives {pc_plus4[WIDTH-1:28], jump_idx, 2'b00}; JREG gives reg_target; RET gives the stack top.
REQ-017 All arithmetic is WIDTH bits, two's complement; wrap-around is silent (0xFFFFFFFC + 4 = 0).
REQ-018 The PC updates one clock edge after inputs are sampled; latency is 1 cycle; pc_plus4 tracks pc_out in the same cycle.
REQ-019 Priority: reset over stall over pc_sel/call.
REQ-020 While stall=1: pc_out, the stack, the status flags and addr_err=0 are all held, with no push or pop.
REQ-021 A candidate with bits [1:0] != 0 (JREG only) leaves pc_out unchanged, pulses addr_err=1 for 1 cycle, and suppresses any push or pop in that cycle.
REQ-022 RET with an empty stack leaves pc_out unchanged, pulses addr_err, and leaves the stack unchanged.
REQ-023 Stack push on call=1 with a valid update: store pc_plus4 and increment the count.
REQ-024 Push while full overwrites the oldest entry (circular); ras_full stays 1.
REQ-025 RET pops the top and decrements the count.
REQ-026 RET with call=1 in the same cycle: pop first, then push the current pc_plus4; the count is unchanged and the top is replaced.
REQ-027 ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both update with the stack.

Reset
REQ-028 While reset_n=0, regardless of clk: pc_out=RESET_VECTOR, count=0, top pointer=0, ras_empty=1, ras_full=0, addr_err=0.
REQ-029 Stack entry contents are not reset; they are unobservable when empty.
REQ-030 Reset asserted mid-operation, including during stall, takes effect immediately and discards pending updates.
REQ-031 The first update after release happens on the first rising edge with reset_n=1.

Structure
REQ-032 The shared package pc_seq_pkg holds the pc_sel encodings (SEL_SEQ..SEL_RET) and the default parameter constants.
REQ-033 The stack is one sub-module, return_addr_stack (push, pop, top, empty, full, parametrised depth and width), containing the circular pointer and count logic.
REQ-034 Next-PC selection and the alignment check stay combinational inside pc_sequencer; the only registers are pc_out and addr_err.

Verification
REQ-035 Reset then SEQ for 3 cycles -> pc_out 0, 4, 8, C; ras_empty=1.
REQ-036 At pc=0x10: BRANCH off=-2 -> 0x0C; JUMP idx=0x40 -> 0x100; JREG 0x202 -> pc held, addr_err pulses 1 cycle.
REQ-037 At pc=0x20: call with JUMP idx=0x100 -> pc 0x400 and top 0x24; RET -> pc 0x24, ras_empty=1.
REQ-038 Five calls with RAS_DEPTH=4 -> ras_full=1 after the 4th; four RETs return the last four pushed addresses in reverse order; a fifth RET gives addr_err with pc held.
REQ-039 Stall=1 for 2 cycles with SEQ and call -> pc, stack and flags unchanged; reset_n=0 during a stall -> pc_out=RESET_VECTOR immediately, without waiting for a clock edge.
REQ-040 pc=0xFFFFFFFC with SEQ -> 0x00000000; simultaneous RET and call -> pc = popped top, new top = old pc+4, count unchanged.
